// File: rtl/fetch_queue_pkg.sv
// Shared fetch-front-end constants and the buffered instruction bundle.
// RESET_PC default is also used by the other stages' restart logic.
package fetch_queue_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] WORD = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_item_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} with push, pop and flush.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_item_t   wdata,
   output fetch_item_t   rdata,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   fetch_item_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited sequential requests,
// in-order response buffering and restart with stale-response discard.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        restart,
   input  logic [31:0] restart_pc,
   input  logic        stall,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        i_valid,
   output logic [31:0] i_instr,
   output logic [31:0] i_pc,
   output logic [31:0] i_npc,
   output logic [31:0] perf_discarded
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] out_next;
   logic [CW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] in_flight;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_push;
   logic          fifo_pop;
   fetch_item_t   fifo_rdata;
   fetch_item_t   rsp_item;
   logic          req_fire;
   logic          rsp_take;
   logic          rsp_drop;
   logic          load_out;
   logic          bypass;

   // The output register is not part of the credit; only the FIFO is.
   assign in_flight = outstanding + fifo_count;
   assign req_valid = reset_n & ~restart
                    & (in_flight < CW'(DEPTH));
   assign req_addr  = fetch_pc;
   assign req_fire  = req_valid & req_ready;

   assign rsp_drop  = rsp_valid & (restart | (discard != '0));
   assign rsp_take  = rsp_valid & ~rsp_drop;
   assign rsp_item  = '{pc: rsp_pc, instr: rsp_data};

   assign load_out  = ~stall | ~i_valid;
   assign bypass    = rsp_take & fifo_empty & load_out;
   assign fifo_push = rsp_take & ~bypass;
   assign fifo_pop  = load_out & ~restart;

   always_comb begin
      out_next = outstanding;
      if (req_fire)  out_next = out_next + CW'(1);
      if (rsp_valid) out_next = out_next - CW'(1);
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (restart),
      .wdata   (rsp_item),
      .rdata   (fifo_rdata),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc       <= RESET_PC;
         rsp_pc         <= RESET_PC;
         outstanding    <= '0;
         discard        <= '0;
         perf_discarded <= '0;
      end else begin
         outstanding <= out_next;
         if (restart) begin
            fetch_pc <= restart_pc;
            rsp_pc   <= restart_pc;
            discard  <= out_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + WORD;
            if (rsp_take) rsp_pc <= rsp_pc + WORD;
            if (rsp_drop) discard <= discard - CW'(1);
         end
         if (rsp_drop) perf_discarded <= perf_discarded + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i_valid <= 1'b0;
         i_instr <= '0;
         i_pc    <= RESET_PC;
         i_npc   <= RESET_PC + WORD;
      end else if (restart) begin
         i_valid <= 1'b0;
      end else if (load_out) begin
         if (!fifo_empty) begin
            i_valid <= 1'b1;
            i_instr <= fifo_rdata.instr;
            i_pc    <= fifo_rdata.pc;
            i_npc   <= fifo_rdata.pc + WORD;
         end else if (bypass) begin
            i_valid <= 1'b1;
            i_instr <= rsp_data;
            i_pc    <= rsp_pc;
            i_npc   <= rsp_pc + WORD;
         end else begin
            i_valid <= 1'b0;
         end
      end
   end

   a_rsp_no_outstanding : assert property (
      @(posedge clock) disable iff (!reset_n)
      !(rsp_valid && outstanding == '0));

   a_push_full : assert property (
      @(posedge clock) disable iff (!reset_n)
      !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-level model
// of the fetch stream, plus directed scenarios with literal checks.
module tb_fetch_queue;

   localparam logic [31:0] RPC = 32'hBFC0_0000;
   localparam int          DEPTH = 4;

   logic        clock;
   logic        reset_n;
   logic        restart;
   logic [31:0] restart_pc;
   logic        stall;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_pc;
   logic [31:0] i_npc;
   logic [31:0] perf_discarded;

   fetch_queue dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .restart        (restart),
      .restart_pc     (restart_pc),
      .stall          (stall),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .i_valid        (i_valid),
      .i_instr        (i_instr),
      .i_pc           (i_pc),
      .i_npc          (i_npc),
      .perf_discarded (perf_discarded)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   mem_t  mq[$];
   exp_t  mm[$];
   item_t disp[$];

   logic [31:0] m_fetch_pc;
   logic [31:0] m_perf;
   int          last_due;
   int          cyc;
   int          lat;
   bit          exp_rv;
   bit          dut_acc;
   logic [31:0] acc_addr;
   int          checks;
   int          failures;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h want=%h",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mm.delete();
      disp.delete();
      m_fetch_pc = RPC;
      m_perf     = '0;
      last_due   = 0;
   endtask

   task automatic check_outputs();
      int fifo_n;
      fifo_n = (disp.size() > 0) ? disp.size() - 1 : 0;
      exp_rv = reset_n && !restart
             && (mm.size() + fifo_n < DEPTH);
      chk("req_valid", req_valid, exp_rv);
      if (exp_rv) chk("req_addr", req_addr, m_fetch_pc);
      chk("i_valid", i_valid, disp.size() > 0);
      if (disp.size() > 0) begin
         chk("i_pc", i_pc, disp[0].pc);
         chk("i_instr", i_instr, disp[0].instr);
         chk("i_npc", i_npc, disp[0].pc + 32'd4);
      end
      chk("perf", perf_discarded, m_perf);
      dut_acc  = req_valid && req_ready;
      acc_addr = req_addr;
   endtask

   task automatic drive(input bit rn, input bit rs,
                        input logic [31:0] rpc,
                        input bit st, input bit rdy);
      @(negedge clock);
      reset_n    = rn;
      restart    = rs;
      restart_pc = rpc;
      stall      = st;
      req_ready  = rdy;
      if (!rn) model_reset();
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (rn && mq.size() > 0 && mq[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = word_of(mq[0].addr);
      end
      #1;
      check_outputs();
   endtask

   task automatic model_update();
      bit    acc;
      item_t ai;
      exp_t  e;
      int    nd;
      acc = 1'b0;
      ai  = '{pc: '0, instr: '0};
      if (rsp_valid) begin
         void'(mq.pop_front());
         if (mm.size() > 0) begin
            e = mm.pop_front();
            if (e.stale || restart) begin
               m_perf = m_perf + 32'd1;
            end else begin
               acc = 1'b1;
               ai  = '{pc: e.pc, instr: word_of(e.pc)};
            end
         end
      end
      if (restart) begin
         foreach (mm[i]) mm[i].stale = 1'b1;
         disp.delete();
         m_fetch_pc = restart_pc;
      end else begin
         if (!stall && disp.size() > 0) void'(disp.pop_front());
         if (acc) disp.push_back(ai);
         if (exp_rv && req_ready) begin
            mm.push_back('{pc: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      if (dut_acc) begin
         nd = cyc + lat;
         if (nd <= last_due) nd = last_due + 1;
         mq.push_back('{addr: acc_addr, due: nd});
         last_due = nd;
      end
   endtask

   task automatic advance();
      @(posedge clock);
      if (reset_n) model_update();
      cyc++;
   endtask

   task automatic step(input bit rs, input logic [31:0] rpc,
                       input bit st, input bit rdy);
      drive(1'b1, rs, rpc, st, rdy);
      advance();
   endtask

   task automatic drain();
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic wait_valid(input string nm, input logic [31:0] pc);
      for (int i = 0; i < 30; i++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (i_valid) begin
            chk(nm, i_pc, pc);
            advance();
            return;
         end
         advance();
      end
      chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] p0;
      logic [31:0] pa;
      logic [31:0] rp;
      bit          rs;
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      lat        = 1;
      reset_n    = 1'b0;
      restart    = 1'b0;
      restart_pc = '0;
      stall      = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      model_reset();

      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("rst_i_valid", i_valid, 32'd0);
      chk("rst_i_instr", i_instr, 32'd0);
      chk("rst_i_pc", i_pc, RPC);
      chk("rst_i_npc", i_npc, RPC + 32'd4);
      chk("rst_req_valid", req_valid, 32'd0);
      chk("rst_perf", perf_discarded, 32'd0);
      advance();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      advance();

      // latency 1, always ready: stream from cycle 3
      for (int k = 1; k <= 12; k++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
         chk("t1_req_addr", req_addr, RPC + 32'(4 * (k - 1)));
         if (k >= 3) begin
            chk("t1_valid", i_valid, 32'd1);
            chk("t1_pc", i_pc, RPC + 32'(4 * (k - 3)));
         end else begin
            chk("t1_valid_early", i_valid, 32'd0);
         end
         advance();
      end

      // latency 3 with a 10-cycle stall
      lat = 3;
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
         if (i == 9) chk("t2_credit_stop", req_valid, 32'd0);
         advance();
      end
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
      p0 = i_pc;
      advance();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
         chk("t2_valid", i_valid, 32'd1);
         chk("t2_order", i_pc, p0 + 32'(4 * k));
         advance();
      end

      // restart with 3 outstanding
      drain();
      pa = perf_discarded;
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 32'h8000_1000, 1'b0, 1'b1);
      chk("t3_no_req", req_valid, 32'd0);
      advance();
      wait_valid("t3_first_pc", 32'h8000_1000);
      chk("t3_discarded", perf_discarded - pa, 32'd3);

      // restart coinciding with a response, 2 outstanding
      drain();
      lat = 2;
      pa = perf_discarded;
      for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 32'h8000_2000, 1'b0, 1'b1);
      chk("t4_no_req", req_valid, 32'd0);
      advance();
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("t4_req_valid", req_valid, 32'd1);
      chk("t4_req_addr", req_addr, 32'h8000_2000);
      advance();
      wait_valid("t4_first_pc", 32'h8000_2000);
      chk("t4_discarded", perf_discarded - pa, 32'd2);

      // back-to-back restarts: B wins
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h0000_1000, 1'b0, 1'b1);
      step(1'b1, 32'h0000_2000, 1'b0, 1'b1);
      wait_valid("t5_first_pc", 32'h0000_2000);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);

      // reset while the FIFO is full
      lat = 1;
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
      chk("t6_i_valid", i_valid, 32'd0);
      chk("t6_req_valid", req_valid, 32'd0);
      advance();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      advance();
      drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
      chk("t6_req_addr", req_addr, RPC);
      advance();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         lat = $urandom_range(1, 4);
         if ($urandom_range(0, 599) == 0) begin
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
            advance();
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
            advance();
         end else begin
            rs = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
               rp = 32'hFFFF_FFF0;
            else
               rp = $urandom() & 32'hFFFF_FFFC;
            step(rs, rp, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
